// File: rtl/b64_1to4_bridge_pkg.sv
// Shared constants and FSM encoding for the 64-bit to 4x16-bit return-path bridge.
package b64_1to4_bridge_pkg;

  localparam int unsigned BEATS_PER_WORD = 4;
  localparam int unsigned BEAT_W         = 16;
  localparam int unsigned WORD_W         = 64;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_WORD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } state_e;

endpackage

// File: rtl/b64_1to4_bridge_if.sv
// Handshake bundle for the bridge: 64-bit word input side and 16-bit FX2 beat output side.
interface b64_1to4_bridge_if;
  import b64_1to4_bridge_pkg::*;

  logic [WORD_W-1:0] d_i;
  logic              d_i_valid;
  logic              d_i_ready;
  logic [BEAT_W-1:0] d_o;
  logic              d_o_valid;
  logic              d_o_ready;
  logic              d_o_last;

  // Environment side: produces words, consumes beats.
  modport master (
    output d_i, d_i_valid, d_o_ready,
    input  d_i_ready, d_o, d_o_valid, d_o_last
  );

  // Bridge side.
  modport slave (
    input  d_i, d_i_valid, d_o_ready,
    output d_i_ready, d_o, d_o_valid, d_o_last
  );

endinterface

// File: rtl/b64_1to4_bridge_sync_fifo64.sv
// Single-clock 64-bit word FIFO with level output; synchronous active-high reset.
module b64_1to4_bridge_sync_fifo64
  import b64_1to4_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [FIFO_AW:0]  level
);

  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/b64_1to4_bridge.sv
// Serializes 64-bit words into four 16-bit beats, MSB half first, toward the FX2 FIFO.
// Define B64_1TO4_BYTESWAP_EN to emit each beat low byte first.
module b64_1to4_bridge
  import b64_1to4_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  b64_1to4_bridge_if.slave    bus,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                busy
);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] fifo_rdata;

  state_e            state_q;
  logic [1:0]        beat_q;
  logic [WORD_W-1:0] sreg_q;
  logic              valid_q;

  logic              beat_acc;
  logic              last_acc;

  assign push     = bus.d_i_valid && !full;
  assign beat_acc = valid_q && bus.d_o_ready;
  assign last_acc = beat_acc && (beat_q == LAST_BEAT);
  // Back-to-back reload on the final beat keeps d_o_valid high with no bubble.
  assign pop      = (state_q == StLoad) || (last_acc && !empty);

  b64_1to4_bridge_sync_fifo64 #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (bus.d_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      sreg_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          sreg_q  <= fifo_rdata;
          beat_q  <= '0;
          valid_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (beat_acc) begin
            if (beat_q == LAST_BEAT) begin
              beat_q <= '0;
              if (!empty) begin
                sreg_q <= fifo_rdata;
              end else begin
                sreg_q  <= '0;
                valid_q <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              sreg_q <= {sreg_q[WORD_W-BEAT_W-1:0], BEAT_W'(0)};
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef B64_1TO4_BYTESWAP_EN
  assign bus.d_o = {sreg_q[WORD_W-BEAT_W +: 8], sreg_q[WORD_W-8 +: 8]};
`else
  assign bus.d_o = sreg_q[WORD_W-1 -: BEAT_W];
`endif

  assign bus.d_o_valid = valid_q;
  assign bus.d_o_last  = valid_q && (beat_q == LAST_BEAT);
  assign bus.d_i_ready = !full;
  assign busy          = !empty || valid_q;

endmodule

// File: tb/tb_b64_1to4_bridge.sv
// Scoreboard bench for b64_1to4_bridge: expected beats queued on push, compared on handshake.
module tb_b64_1to4_bridge;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] fifo_level;
  logic       busy;

  b64_1to4_bridge_if bus ();

  b64_1to4_bridge #(
    .FIFO_DEPTH (4),
    .FIFO_AW    (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q [$];

  logic [15:0] held_d;
  logic        held_last;
  logic        in_stall = 1'b0;
  logic        ready_low_seen = 1'b0;
  logic [2:0]  max_level = '0;
  int          drops;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] fmt_beat(input logic [63:0] w, input int k);
    logic [15:0] h;
    h = 16'(w >> (48 - 16 * k));
`ifdef B64_1TO4_BYTESWAP_EN
    h = {h[7:0], h[15:8]};
`endif
    return h;
  endfunction

  task automatic push_exp(input logic [63:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), fmt_beat(w, k)});
  endtask

  // Called at posedge+1; word is accepted on the next posedge where d_i_ready is high.
  task automatic send_word(input logic [63:0] w);
    int n;
    n = 0;
    bus.d_i       = w;
    bus.d_i_valid = 1'b1;
    @(negedge clk_i);
    while (!bus.d_i_ready && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.d_i_ready) check_eq("d_i_ready timeout", 0, 1);
    else push_exp(w);
    @(posedge clk_i);
    #1;
    bus.d_i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("drain complete", ((exp_q.size() == 0) && !busy), 1);
  endtask

  always @(negedge clk_i) begin
    logic [16:0] e;
    if (!rst_i) begin
      if (!bus.d_i_ready) ready_low_seen <= 1'b1;
      if (fifo_level > max_level) max_level <= fifo_level;
      if (bus.d_o_valid && bus.d_o_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected beat", bus.d_o, 64'hdead);
        else begin
          e = exp_q.pop_front();
          check_eq("beat data", bus.d_o, e[15:0]);
          check_eq("beat last", bus.d_o_last, e[16]);
        end
        in_stall = 1'b0;
      end else if (bus.d_o_valid && !bus.d_o_ready) begin
        if (in_stall) begin
          check_eq("stall hold data", bus.d_o, held_d);
          check_eq("stall hold last", bus.d_o_last, held_last);
        end
        held_d    = bus.d_o;
        held_last = bus.d_o_last;
        in_stall  = 1'b1;
      end else begin
        in_stall = 1'b0;
      end
    end
  end

  initial begin
    int n;
    bus.d_i       = '0;
    bus.d_i_valid = 1'b0;
    bus.d_o_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check_eq("rst d_o", bus.d_o, 0);
    check_eq("rst d_o_valid", bus.d_o_valid, 0);
    check_eq("rst d_o_last", bus.d_o_last, 0);
    check_eq("rst fifo_level", fifo_level, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst d_i_ready", bus.d_i_ready, 1);
    @(posedge clk_i);
    #1;

    // Single word, latency N+2
    send_word(64'h0123_4567_89AB_CDEF);
    @(negedge clk_i);
    check_eq("lat level after push", fifo_level, 1);
    check_eq("lat busy", busy, 1);
    check_eq("lat valid N+0", bus.d_o_valid, 0);
    @(negedge clk_i);
    check_eq("lat valid N+1", bus.d_o_valid, 0);
    @(negedge clk_i);
    check_eq("lat valid N+2", bus.d_o_valid, 1);
    check_eq("lat first beat", bus.d_o, fmt_beat(64'h0123_4567_89AB_CDEF, 0));
    wait_drain();
    check_eq("idle valid", bus.d_o_valid, 0);

    // 8 back-to-back words, no gaps in output
    @(posedge clk_i);
    #1;
    ready_low_seen = 1'b0;
    max_level      = '0;
    drops          = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_word({$urandom, $urandom});
      end
      begin
        n = 0;
        while (!bus.d_o_valid && n < 20) begin
          @(negedge clk_i);
          n++;
        end
        for (int i = 0; i < 31; i++) begin
          @(negedge clk_i);
          if (!bus.d_o_valid) drops++;
        end
      end
    join
    wait_drain();
    check_eq("b2b no valid drops", drops, 0);
    check_eq("b2b d_i_ready dropped", ready_low_seen, 1);
    check_eq("b2b max level", max_level, 4);

    // Stall 5 cycles on beat 1
    @(posedge clk_i);
    #1;
    send_word(64'hA5A5_1234_5A5A_9876);
    n = 0;
    while (!bus.d_o_valid && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(posedge clk_i);
    #1 bus.d_o_ready = 1'b0;
    check_eq("stall beat1 shown", bus.d_o, fmt_beat(64'hA5A5_1234_5A5A_9876, 1));
    repeat (5) @(posedge clk_i);
    #1;
    check_eq("stall beat1 kept", bus.d_o, fmt_beat(64'hA5A5_1234_5A5A_9876, 1));
    bus.d_o_ready = 1'b1;
    wait_drain();

    // Fill with d_o_ready low: one word sits in the serializer, four in the FIFO
    @(posedge clk_i);
    #1 bus.d_o_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(64'h1111_0000_0000_0000 * (i + 1) + 64'(i));
    @(negedge clk_i);
    check_eq("full d_i_ready", bus.d_i_ready, 0);
    check_eq("full level", fifo_level, 4);
    @(posedge clk_i);
    #1;
    bus.d_i       = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.d_i_valid = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 bus.d_i_valid = 1'b0;
    check_eq("full level after extra", fifo_level, 4);
    bus.d_o_ready = 1'b1;
    wait_drain();

    // Reset during beat 2 with two words queued
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom});
    n = 0;
    while (!bus.d_o_valid && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("pre-rst level", fifo_level, 2);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_eq("mid rst d_o", bus.d_o, 0);
    check_eq("mid rst d_o_valid", bus.d_o_valid, 0);
    check_eq("mid rst d_o_last", bus.d_o_last, 0);
    check_eq("mid rst level", fifo_level, 0);
    check_eq("mid rst busy", busy, 0);
    check_eq("mid rst d_i_ready", bus.d_i_ready, 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (bus.d_o_valid) n++;
    end
    check_eq("no residual beats", n, 0);

    // Push coinciding with final-beat pop at level 1
    @(posedge clk_i);
    #1;
    send_word(64'hFEDC_BA98_7654_3210);
    send_word(64'h0F0F_F0F0_3C3C_C3C3);
    repeat (4) @(posedge clk_i);
    #1;
    check_eq("coinc last beat", bus.d_o_last, 1);
    check_eq("coinc level before", fifo_level, 1);
    send_word(64'h7777_8888_9999_AAAA);
    check_eq("coinc level after", fifo_level, 1);
    check_eq("coinc no bubble", bus.d_o_valid, 1);
    check_eq("coinc next beat0", bus.d_o, fmt_beat(64'h0F0F_F0F0_3C3C_C3C3, 0));
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
